// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encodings, grant ids and timeout default for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    localparam logic [7:0] TIMEOUT_DEFAULT = 8'd255;

    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin pick; on a tie the requester not granted last wins
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    always_comb begin
        grant = GNT_A;
        if (req == 2'b11)
            grant = ~last;
        else if (req[1])
            grant = GNT_B;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates two requesters onto one memory-controller port with ack timeout
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        MCU_CLK,
    input  logic        RST_SYS,
    input  logic        a_act,
    input  logic        b_act,
    input  logic        a_we,
    input  logic        b_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] b_addr,
    input  logic [31:0] a_wdata,
    input  logic [31:0] b_wdata,
    input  logic [3:0]  a_we_array,
    input  logic [3:0]  b_we_array,
    output logic        a_ack,
    output logic        b_ack,
    output logic        a_err,
    output logic        b_err,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_we_array,
    output logic [31:0] mem_dataintomem,
    output logic        mem_do_act,
    input  logic        mem_ack,
    input  logic [31:0] mem_datafrommem,
    output logic        busy
);

    arb_state_t  state;
    logic        last_gnt;
    logic        gnt_id;
    logic        pick;
    logic [7:0]  wait_cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;

    rr_pick2 u_rr_pick2 (
        .req   ({b_act, a_act}),
        .last  (last_gnt),
        .grant (pick)
    );

    assign busy = (state != ST_IDLE);

    always_ff @(posedge MCU_CLK) begin
        if (RST_SYS) begin
            state           <= ST_IDLE;
            last_gnt        <= GNT_B;
            gnt_id          <= GNT_A;
            wait_cnt        <= 8'd0;
            lat_we          <= 1'b0;
            lat_addr        <= 32'd0;
            lat_wdata       <= 32'd0;
            lat_be          <= 4'd0;
            a_ack           <= 1'b0;
            b_ack           <= 1'b0;
            a_err           <= 1'b0;
            b_err           <= 1'b0;
            rdata           <= 32'd0;
            mem_addr        <= 32'd0;
            mem_we          <= 1'b0;
            mem_we_array    <= 4'd0;
            mem_dataintomem <= 32'd0;
            mem_do_act      <= 1'b0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            a_err <= 1'b0;
            b_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (a_act || b_act) begin
                        gnt_id <= pick;
                        if (pick == GNT_B) begin
                            lat_we    <= b_we;
                            lat_addr  <= b_addr;
                            lat_wdata <= b_wdata;
                            lat_be    <= b_we_array;
                        end else begin
                            lat_we    <= a_we;
                            lat_addr  <= a_addr;
                            lat_wdata <= a_wdata;
                            lat_be    <= a_we_array;
                        end
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_do_act      <= 1'b1;
                    mem_addr        <= lat_addr;
                    mem_we          <= lat_we;
                    mem_we_array    <= lat_be;
                    mem_dataintomem <= lat_wdata;
                    wait_cnt        <= 8'd0;
                    state           <= ST_WAIT;
                end
                ST_WAIT: begin
                    // mem_ack is tested first so a late ack beats the timeout in the same cycle
                    if (mem_ack) begin
                        mem_do_act      <= 1'b0;
                        mem_dataintomem <= 32'd0;
                        if (!mem_we)
                            rdata <= mem_datafrommem;
                        a_ack <= (gnt_id == GNT_A);
                        b_ack <= (gnt_id == GNT_B);
                        state <= ST_RELEASE;
                    end else if (wait_cnt == TIMEOUT) begin
                        mem_do_act      <= 1'b0;
                        mem_dataintomem <= 32'd0;
                        a_err <= (gnt_id == GNT_A);
                        b_err <= (gnt_id == GNT_B);
                        state <= ST_RELEASE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_RELEASE: begin
                    last_gnt <= gnt_id;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with directed requests
module tb_mem_port_arbiter;

    logic        MCU_CLK;
    logic        RST_SYS;
    logic        a_act, b_act, a_we, b_we;
    logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
    logic [3:0]  a_we_array, b_we_array;
    logic        a_ack, b_ack, a_err, b_err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_we_array;
    logic [31:0] mem_dataintomem;
    logic        mem_do_act;
    logic        mem_ack;
    logic [31:0] mem_datafrommem;
    logic        busy;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    typedef struct {
        logic        id;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } rsp_t;

    req_t exp_req[$];
    rsp_t exp_rsp[$];

    int          checks = 0;
    int          errors = 0;
    int          rsp_delay = -1;
    logic        rsp_fixed = 1'b0;
    logic [31:0] rsp_data = 32'd0;

    mem_port_arbiter #(.TIMEOUT(8'd4)) dut (
        .MCU_CLK         (MCU_CLK),
        .RST_SYS         (RST_SYS),
        .a_act           (a_act),
        .b_act           (b_act),
        .a_we            (a_we),
        .b_we            (b_we),
        .a_addr          (a_addr),
        .b_addr          (b_addr),
        .a_wdata         (a_wdata),
        .b_wdata         (b_wdata),
        .a_we_array      (a_we_array),
        .b_we_array      (b_we_array),
        .a_ack           (a_ack),
        .b_ack           (b_ack),
        .a_err           (a_err),
        .b_err           (b_err),
        .rdata           (rdata),
        .mem_addr        (mem_addr),
        .mem_we          (mem_we),
        .mem_we_array    (mem_we_array),
        .mem_dataintomem (mem_dataintomem),
        .mem_do_act      (mem_do_act),
        .mem_ack         (mem_ack),
        .mem_datafrommem (mem_datafrommem),
        .busy            (busy)
    );

    initial MCU_CLK = 1'b0;
    always #5 MCU_CLK = ~MCU_CLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic expect_txn(input logic id, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input logic err, input logic [31:0] rd, input int lat);
        req_t q;
        rsp_t r;
        q.we = we; q.addr = addr; q.wdata = wdata; q.be = be;
        r.id = id; r.err = err; r.rdata = rd; r.lat = lat;
        exp_req.push_back(q);
        exp_rsp.push_back(r);
    endtask

    task automatic do_req(input logic id, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
        logic done;
        @(negedge MCU_CLK);
        if (id == 1'b0) begin
            a_we = we; a_addr = addr; a_wdata = wdata; a_we_array = be; a_act = 1'b1;
        end else begin
            b_we = we; b_addr = addr; b_wdata = wdata; b_we_array = be; b_act = 1'b1;
        end
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge MCU_CLK);
            done = (id == 1'b0) ? (a_ack | a_err) : (b_ack | b_err);
        end
        chk("req_completed", {31'd0, done}, 32'd1);
        if (id == 1'b0) a_act = 1'b0;
        else            b_act = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_do_act"}, {31'd0, mem_do_act}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_ctl"}, {27'd0, mem_we, mem_we_array}, 32'd0);
        chk({tag, "_mem_wdata"}, mem_dataintomem, 32'd0);
        chk({tag, "_ack_err_busy"}, {27'd0, a_ack, b_ack, a_err, b_err, busy}, 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
    endtask

    // memory-controller model: acks rsp_delay cycles after mem_do_act rises, never when negative
    initial begin
        int   wcnt;
        logic rsp_done;
        wcnt = 0;
        rsp_done = 1'b0;
        mem_ack = 1'b0;
        mem_datafrommem = 32'hFFFF_FFFF;
        forever begin
            @(negedge MCU_CLK);
            mem_ack = 1'b0;
            mem_datafrommem = 32'hFFFF_FFFF;
            if (mem_do_act && !rsp_done) begin
                if (wcnt == rsp_delay) begin
                    mem_ack = 1'b1;
                    mem_datafrommem = rsp_fixed ? rsp_data : (mem_addr ^ 32'hA5A5_0000);
                    rsp_done = 1'b1;
                end
                wcnt++;
            end else if (!mem_do_act) begin
                wcnt = 0;
                rsp_done = 1'b0;
            end
        end
    end

    // monitor: compares issued requests and responses against the scoreboard queues
    initial begin
        int          cyc;
        int          rise_cyc;
        logic        prev_do;
        req_t        q;
        rsp_t        r;
        cyc = 0;
        rise_cyc = 0;
        prev_do = 1'b0;
        forever begin
            @(negedge MCU_CLK);
            cyc++;
            if (mem_do_act && !prev_do) begin
                rise_cyc = cyc;
                if (exp_req.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_issue: addr %h, no request expected", mem_addr);
                end else begin
                    q = exp_req.pop_front();
                    chk("issue_addr", mem_addr, q.addr);
                    chk("issue_we", {31'd0, mem_we}, {31'd0, q.we});
                    chk("issue_be", {28'd0, mem_we_array}, {28'd0, q.be});
                    chk("issue_wdata", mem_dataintomem, q.wdata);
                end
            end else if (mem_do_act && prev_do) begin
                chk("hold_addr", mem_addr, q.addr);
                chk("hold_ctl", {27'd0, mem_we, mem_we_array}, {27'd0, q.we, q.be});
                chk("hold_wdata", mem_dataintomem, q.wdata);
            end
            if (mem_do_act)
                chk("busy_in_wait", {31'd0, busy}, 32'd1);
            if (a_ack | b_ack | a_err | b_err) begin
                if (exp_rsp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp: ack=%b%b err=%b%b, none expected", a_ack, b_ack, a_err, b_err);
                end else begin
                    r = exp_rsp.pop_front();
                    chk("rsp_one_pulse", $countones({a_ack, b_ack, a_err, b_err}), 32'd1);
                    chk("rsp_id", {31'd0, b_ack | b_err}, {31'd0, r.id});
                    chk("rsp_is_err", {31'd0, a_err | b_err}, {31'd0, r.err});
                    chk("rsp_rdata", rdata, r.rdata);
                    chk("rsp_latency", cyc - rise_cyc, r.lat);
                    chk("rsp_do_act_low", {31'd0, mem_do_act}, 32'd0);
                    chk("rsp_wdata_cleared", mem_dataintomem, 32'd0);
                end
            end
            prev_do = mem_do_act;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic seen;
        RST_SYS = 1'b1;
        a_act = 1'b0; b_act = 1'b0; a_we = 1'b0; b_we = 1'b0;
        a_addr = 32'd0; b_addr = 32'd0; a_wdata = 32'd0; b_wdata = 32'd0;
        a_we_array = 4'd0; b_we_array = 4'd0;
        repeat (3) @(negedge MCU_CLK);
        chk_all_zero("reset");
        RST_SYS = 1'b0;

        // tie straight after reset, then both keep re-requesting: A, B, A, B
        rsp_fixed = 1'b0; rsp_delay = 1;
        expect_txn(1'b0, 1'b0, 32'h0000_0100, 32'd0, 4'hF, 1'b0, 32'hA5A5_0100, 2);
        expect_txn(1'b1, 1'b0, 32'h0000_0200, 32'd0, 4'hF, 1'b0, 32'hA5A5_0200, 2);
        expect_txn(1'b0, 1'b0, 32'h0000_0104, 32'd0, 4'hF, 1'b0, 32'hA5A5_0104, 2);
        expect_txn(1'b1, 1'b0, 32'h0000_0204, 32'd0, 4'hF, 1'b0, 32'hA5A5_0204, 2);
        fork
            begin
                do_req(1'b0, 1'b0, 32'h0000_0100, 32'd0, 4'hF);
                do_req(1'b0, 1'b0, 32'h0000_0104, 32'd0, 4'hF);
            end
            begin
                do_req(1'b1, 1'b0, 32'h0000_0200, 32'd0, 4'hF);
                do_req(1'b1, 1'b0, 32'h0000_0204, 32'd0, 4'hF);
            end
        join

        // single read, mem_ack two cycles after mem_do_act
        rsp_fixed = 1'b1; rsp_data = 32'hDEAD_BEEF; rsp_delay = 2;
        expect_txn(1'b0, 1'b0, 32'h0000_0040, 32'd0, 4'hF, 1'b0, 32'hDEAD_BEEF, 3);
        do_req(1'b0, 1'b0, 32'h0000_0040, 32'd0, 4'hF);

        // write leaves rdata alone even though the controller returns data
        rsp_fixed = 1'b0; rsp_delay = 1;
        expect_txn(1'b1, 1'b1, 32'h0000_1000, 32'h1234_5678, 4'b1100, 1'b0, 32'hDEAD_BEEF, 2);
        do_req(1'b1, 1'b1, 32'h0000_1000, 32'h1234_5678, 4'b1100);

        // timeout abort, then a normal B read
        rsp_delay = -1;
        expect_txn(1'b0, 1'b0, 32'h0000_2000, 32'd0, 4'hF, 1'b1, 32'hDEAD_BEEF, 5);
        do_req(1'b0, 1'b0, 32'h0000_2000, 32'd0, 4'hF);
        rsp_delay = 0;
        expect_txn(1'b1, 1'b0, 32'h0000_3000, 32'd0, 4'hF, 1'b0, 32'hA5A5_3000, 1);
        do_req(1'b1, 1'b0, 32'h0000_3000, 32'd0, 4'hF);

        // last cycle before timeout, then ack colliding with the timeout
        rsp_delay = 3;
        expect_txn(1'b1, 1'b0, 32'h0000_0048, 32'd0, 4'hF, 1'b0, 32'hA5A5_0048, 4);
        do_req(1'b1, 1'b0, 32'h0000_0048, 32'd0, 4'hF);
        rsp_delay = 4;
        expect_txn(1'b0, 1'b0, 32'h0000_0044, 32'd0, 4'hF, 1'b0, 32'hA5A5_0044, 5);
        do_req(1'b0, 1'b0, 32'h0000_0044, 32'd0, 4'hF);

        // reset while an A read is waiting: no ack or err, everything cleared
        rsp_delay = -1;
        begin
            req_t q;
            q.we = 1'b0; q.addr = 32'h0000_0080; q.wdata = 32'd0; q.be = 4'hF;
            exp_req.push_back(q);
        end
        @(negedge MCU_CLK);
        a_we = 1'b0; a_addr = 32'h0000_0080; a_wdata = 32'd0; a_we_array = 4'hF; a_act = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge MCU_CLK);
            seen = mem_do_act;
        end
        chk("reset_test_issued", {31'd0, seen}, 32'd1);
        @(negedge MCU_CLK);
        RST_SYS = 1'b1;
        @(negedge MCU_CLK);
        RST_SYS = 1'b0;
        a_act = 1'b0;
        chk_all_zero("mid_wait_reset");
        repeat (10) @(negedge MCU_CLK);

        rsp_delay = 2;
        expect_txn(1'b0, 1'b0, 32'h0000_0084, 32'd0, 4'hF, 1'b0, 32'hA5A5_0084, 3);
        do_req(1'b0, 1'b0, 32'h0000_0084, 32'd0, 4'hF);

        repeat (5) @(negedge MCU_CLK);
        chk("req_queue_drained", exp_req.size(), 32'd0);
        chk("rsp_queue_drained", exp_rsp.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd255: max cycles to wait for mem_ack before aborting.
REQ-002 SHALL have port MCU_CLK  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port RST_SYS  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports a_act / b_act  in  1  requester A/B request, level, held until its ack or err.
REQ-005 SHALL have ports a_we / b_we  in  1  requester write (1) or read (0).
REQ-006 SHALL have ports a_addr / b_addr  in  32  requester word address.
REQ-007 SHALL have ports a_wdata / b_wdata  in  32  requester write data.
REQ-008 SHALL have ports a_we_array / b_we_array  in  4  requester byte-lane enables.
REQ-009 SHALL have ports a_ack / b_ack  out  1  one-cycle completion pulse.
REQ-010 SHALL have ports a_err / b_err  out  1  one-cycle timeout-abort pulse.
REQ-011 SHALL have port rdata  out  32  read data, valid in the cycle of the matching ack.
REQ-012 SHALL have ports mem_addr (out 32), mem_we (out 1), mem_we_array (out 4), mem_dataintomem (out 32), mem_do_act (out 1): memory-controller request side.
REQ-013 SHALL have ports mem_ack (in 1) and mem_datafrommem (in 32): memory-controller response side.
REQ-014 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RELEASE -> IDLE, one transition per cycle except WAIT.
REQ-016 IDLE: on any act high SHALL pick a winner, latch its addr/we/wdata/we_array and the grant id, then go to ISSUE.
REQ-017 Arbitration SHALL be round-robin: when both act are high, the requester not granted last wins; after reset, A wins the first tie.
REQ-018 A single requester SHALL win immediately, regardless of the round-robin pointer.
REQ-019 ISSUE: SHALL drive mem_do_act=1, mem_addr, mem_we, mem_we_array and mem_dataintomem from the latched values, then go to WAIT.
REQ-020 WAIT: SHALL hold all mem_* outputs stable until mem_ack is sampled high.
REQ-021 On mem_ack in WAIT: SHALL drop mem_do_act, clear mem_dataintomem to 0, latch mem_datafrommem into rdata (reads only), pulse the granted ack, and go to RELEASE.
REQ-022 Latency SHALL be: ack pulse exactly one cycle after the mem_ack sample edge; minimum request-to-ack time 3 cycles.
REQ-023 The 8-bit wait counter SHALL clear on entering WAIT and increment each WAIT cycle without mem_ack.
REQ-024 When the counter equals TIMEOUT, the block SHALL drop mem_do_act, pulse the granted err (no ack), leave rdata unchanged, and go to RELEASE.
REQ-025 If mem_ack and the timeout occur in the same cycle, ack SHALL win and err SHALL NOT pulse.
REQ-026 RELEASE: SHALL update the round-robin pointer to the grant id, ignore all act for this cycle, then go to IDLE (the requester deasserts act in this cycle).
REQ-027 mem_ack outside WAIT SHALL be ignored.
REQ-028 rdata SHALL hold its value until the next successful read.
REQ-029 A non-granted requester's act SHALL be held pending without loss; it wins the next IDLE.

Reset
REQ-030 RST_SYS high at any clock edge, including mid-WAIT, SHALL force: state IDLE, all mem_* outputs 0, ack/err 0, busy 0, rdata 0, counter 0, pointer = B-last (so A wins the first tie). An aborted transfer gets no ack or err.

Structure
REQ-031 FSM state encodings and the TIMEOUT default SHALL live in the shared package mem_arb_pkg.
REQ-032 Round-robin selection SHALL be a sub-module rr_pick2 (inputs req[1:0] and last; output grant id); everything else stays flat.

Verification
REQ-033 Single read: A read at addr 32'h0000_0040, mem_ack two cycles after mem_do_act, mem_datafrommem=32'hDEAD_BEEF -> a_ack one cycle after mem_ack, rdata=32'hDEAD_BEEF, b_ack stays 0.
REQ-034 Tie: a_act and b_act rise in the same cycle, then both re-request repeatedly -> grant order A, B, A, B; each mem_addr matches its requester.
REQ-035 Write: B write, addr 32'h0000_1000, wdata 32'h1234_5678, we_array 4'b1100 -> those values on mem_* while mem_do_act is high; mem_dataintomem is 0 after mem_ack; rdata unchanged.
REQ-036 Timeout: TIMEOUT=8'd4, mem_ack never asserted -> a_err pulses once, a_ack stays 0, mem_do_act low; the next B request is served normally.
REQ-037 Reset mid-WAIT: RST_SYS high for one cycle during a pending A read -> all outputs 0 next cycle, no a_ack/a_err, and a fresh A request completes normally.
REQ-038 Collision: mem_ack in the same cycle the counter reaches TIMEOUT -> ack only, no err.
